// File: rtl/wb_stage.sv
// Writeback stage: ALU results and queued load results merged onto one register-file write port.
// Optional WB_BYPASS_EN adds combinational forwarding of the registered write to two read ports.
module wb_stage #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int QDEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [$clog2(DEPTH)-1:0]   alu_rd,
  input  logic [WIDTH-1:0]           alu_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [$clog2(DEPTH)-1:0]   ld_rd,
  input  logic [WIDTH-1:0]           ld_data,
  output logic                       we0,
  output logic [$clog2(DEPTH)-1:0]   wr_addr0,
  output logic [WIDTH-1:0]           wr_din0,
  output logic [DEPTH-1:0]           busy_mask,
  output logic [$clog2(QDEPTH):0]    q_count
`ifdef WB_BYPASS_EN
  ,
  input  logic [$clog2(DEPTH)-1:0]   rs1_addr,
  input  logic [$clog2(DEPTH)-1:0]   rs2_addr,
  input  logic [WIDTH-1:0]           rs1_rf,
  input  logic [WIDTH-1:0]           rs2_rf,
  output logic [WIDTH-1:0]           rs1_val,
  output logic [WIDTH-1:0]           rs2_val
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int QAW = $clog2(QDEPTH);
  localparam int CW  = QAW + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  typedef struct packed {
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] data;
  } ent_t;

  ent_t             mem_q [QDEPTH];
  logic [QAW-1:0]   head_q, head_d;
  logic [QAW-1:0]   tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] din_q, din_d;

  logic             push, pop, sel;
  ent_t             sel_e;
  logic [DEPTH-1:0] busy;
  logic [QAW-1:0]   idx;

  assign ld_ready = !rst && (cnt_q != QFULL);
  assign push     = ld_valid && ld_ready;
  // ALU always wins the port; loads drain only on ALU-idle cycles
  assign pop      = !alu_valid && (cnt_q != '0);

  always_comb begin
    sel   = 1'b0;
    sel_e = '0;
    unique case (1'b1)
      alu_valid: begin
        sel   = 1'b1;
        sel_e = '{rd: alu_rd, data: alu_data};
      end
      pop: begin
        sel   = 1'b1;
        sel_e = mem_q[head_q];
      end
      default: ;
    endcase
  end

  always_comb begin
    we_d   = sel && (sel_e.rd != '0);
    addr_d = we_d ? sel_e.rd : addr_q;
    din_d  = we_d ? sel_e.data : din_q;
    head_d = head_q + QAW'(pop);
    tail_d = tail_q + QAW'(push);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end

  // Storage needs no reset: occupancy alone marks entries valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= '{rd: ld_rd, data: ld_data};
    end
  end

  always_comb begin
    busy = '0;
    idx  = '0;
    if (we_q) begin
      busy[addr_q] = 1'b1;
    end
    for (int i = 0; i < QDEPTH; i++) begin
      idx = head_q + QAW'(i);
      if (CW'(i) < cnt_q) begin
        busy[mem_q[idx].rd] = 1'b1;
      end
    end
    busy[0] = 1'b0;
  end

  assign we0       = we_q;
  assign wr_addr0  = addr_q;
  assign wr_din0   = din_q;
  assign busy_mask = busy;
  assign q_count   = cnt_q;

`ifdef WB_BYPASS_EN
  assign rs1_val = (we_q && addr_q == rs1_addr && rs1_addr != '0)
                   ? din_q : rs1_rf;
  assign rs2_val = (we_q && addr_q == rs2_addr && rs2_addr != '0)
                   ? din_q : rs2_rf;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: a reference model predicts each edge's
// write, occupancy and busy mask; a monitor compares after every edge.
module tb_wb_stage;

  localparam int QD = 4;

  logic        clk, rst;
  logic        alu_valid, ld_valid, ld_ready;
  logic [4:0]  alu_rd, ld_rd, wr_addr0;
  logic [31:0] alu_data, ld_data, wr_din0;
  logic        we0;
  logic [31:0] busy_mask;
  logic [2:0]  q_count;
`ifdef WB_BYPASS_EN
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_rf, rs2_rf, rs1_val, rs2_val;
`endif

  wb_stage #(.WIDTH(32), .DEPTH(32), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_rd(ld_rd), .ld_data(ld_data),
    .we0(we0), .wr_addr0(wr_addr0), .wr_din0(wr_din0),
    .busy_mask(busy_mask), .q_count(q_count)
`ifdef WB_BYPASS_EN
    , .rs1_addr(rs1_addr), .rs2_addr(rs2_addr)
    , .rs1_rf(rs1_rf), .rs2_rf(rs2_rf)
    , .rs1_val(rs1_val), .rs2_val(rs2_val)
`endif
  );

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ld_t;

  exp_t        exp_q[$];
  ld_t         mq[$];
  exp_t        ex;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          n_cmp, n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    if (m_we) b[m_addr] = 1'b1;
    foreach (mq[i]) b[mq[i].rd] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // Drives one cycle of stimulus and queues the model's prediction for the edge.
  task automatic step(input logic av, input logic [4:0] ar,
                      input logic [31:0] ad, input logic lv,
                      input logic [4:0] lr, input logic [31:0] ld,
                      output logic acc);
    ld_t  e;
    logic sel;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_valid = lv; ld_rd = lr; ld_data = ld;
    acc = lv && (mq.size() < QD);
    sel = 1'b0;
    e = '{rd: 5'd0, d: 32'd0};
    if (av) begin
      sel = 1'b1;
      e = '{rd: ar, d: ad};
    end else if (mq.size() > 0) begin
      sel = 1'b1;
      e = mq.pop_front();
    end
    if (acc) mq.push_back('{rd: lr, d: ld});
    m_we = sel && (e.rd != 5'd0);
    if (m_we) begin
      m_addr = e.rd;
      m_data = e.d;
    end
    exp_q.push_back('{we: m_we, a: m_addr, d: m_data});
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      n_cmp += 5;
      if (we0 !== ex.we) begin
        n_bad++;
        $display("FAIL mon_we0 t=%0t got %b want %b", $time, we0, ex.we);
      end
      if (wr_addr0 !== ex.a || wr_din0 !== ex.d) begin
        n_bad++;
        $display("FAIL mon_wr t=%0t got %0d/%h want %0d/%h",
                 $time, wr_addr0, wr_din0, ex.a, ex.d);
      end
      if (q_count !== 3'(mq.size())) begin
        n_bad++;
        $display("FAIL mon_qcount t=%0t got %0d want %0d",
                 $time, q_count, mq.size());
      end
      if (busy_mask !== model_busy()) begin
        n_bad++;
        $display("FAIL mon_busy t=%0t got %h want %h",
                 $time, busy_mask, model_busy());
      end
      if (ld_ready !== (mq.size() != QD)) begin
        n_bad++;
        $display("FAIL mon_ready t=%0t got %b want %b",
                 $time, ld_ready, mq.size() != QD);
      end
    end
  end

  task automatic test_reset();
    logic acc;
    #3;
    n_cmp++;
    if (we0 !== 1'b0 || wr_addr0 !== 5'd0 || wr_din0 !== 32'd0 ||
        q_count !== 3'd0 || busy_mask !== 32'd0 || ld_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_hold got we%b a%0d d%h q%0d b%h r%b want all 0",
               we0, wr_addr0, wr_din0, q_count, busy_mask, ld_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ld_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_release_ready got %b want 1", ld_ready);
    end
    for (int k = 0; k < 3; k++)
      step(1'b1, 5'(20 + k), 32'hA0 + 32'(k), 1'b1, 5'(1 + k), 32'h10 + 32'(k), acc);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (we0 !== 1'b0 || q_count !== 3'd0 || busy_mask !== 32'd0 ||
        ld_ready !== 1'b0 || wr_addr0 !== 5'd0 || wr_din0 !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_mid got we%b q%0d b%h r%b a%0d d%h want all 0",
               we0, q_count, busy_mask, ld_ready, wr_addr0, wr_din0);
    end
    model_clear();
    alu_valid = 1'b0;
    ld_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ld_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_release_ready got %b want 1", ld_ready);
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
  endtask

  task automatic test_alu();
    logic acc;
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, acc);
    n_cmp++;
    if (we0 !== 1'b1 || wr_addr0 !== 5'd5 || wr_din0 !== 32'h1234 ||
        busy_mask[5] !== 1'b1) begin
      n_bad++;
      $display("FAIL alu_write got we%b a%0d d%h b5=%b want 1/5/1234/1",
               we0, wr_addr0, wr_din0, busy_mask[5]);
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
    n_cmp++;
    if (we0 !== 1'b0 || busy_mask !== 32'd0 || wr_din0 !== 32'h1234) begin
      n_bad++;
      $display("FAIL alu_idle_hold got we%b b%h d%h want 0/0/1234",
               we0, busy_mask, wr_din0);
    end
  endtask

  task automatic test_queue_full();
    logic       acc;
    logic [4:0] cand;
    cand = 5'd1;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 5'(10 + k), 32'hB0 + 32'(k), 1'b1, cand, 32'hC0 + 32'(cand), acc);
      if (acc) cand++;
    end
    n_cmp++;
    if (ld_ready !== 1'b0 || q_count !== 3'd4) begin
      n_bad++;
      $display("FAIL full_state got ready%b q%0d want 0/4", ld_ready, q_count);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
      n_cmp++;
      if (we0 !== 1'b1 || wr_addr0 !== 5'(k + 1) || wr_din0 !== 32'hC1 + 32'(k)) begin
        n_bad++;
        $display("FAIL full_drain%0d got we%b a%0d d%h want 1/%0d/%h",
                 k, we0, wr_addr0, wr_din0, k + 1, 32'hC1 + 32'(k));
      end
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
  endtask

  task automatic test_priority();
    logic acc;
    step(1'b1, 5'd11, 32'h55, 1'b1, 5'd7, 32'h77, acc);
    step(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, acc);
    n_cmp++;
    if (wr_addr0 !== 5'd9 || wr_din0 !== 32'h99 || q_count !== 3'd1 ||
        busy_mask[7] !== 1'b1 || busy_mask[9] !== 1'b1) begin
      n_bad++;
      $display("FAIL prio_alu got a%0d d%h q%0d b%h want 9/99/1 b7,b9",
               wr_addr0, wr_din0, q_count, busy_mask);
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
    n_cmp++;
    if (we0 !== 1'b1 || wr_addr0 !== 5'd7 || wr_din0 !== 32'h77 || q_count !== 3'd0) begin
      n_bad++;
      $display("FAIL prio_load got we%b a%0d d%h q%0d want 1/7/77/0",
               we0, wr_addr0, wr_din0, q_count);
    end
  endtask

  task automatic test_x0();
    logic acc;
    step(1'b1, 5'd12, 32'h1, 1'b1, 5'd0, 32'hFFFF, acc);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
    n_cmp++;
    if (we0 !== 1'b0 || busy_mask !== 32'd0 || q_count !== 3'd0 ||
        wr_addr0 !== 5'd12 || wr_din0 !== 32'h1) begin
      n_bad++;
      $display("FAIL x0_discard got we%b b%h q%0d a%0d d%h want 0/0/0/12/1",
               we0, busy_mask, q_count, wr_addr0, wr_din0);
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom, acc);
    for (int k = 0; k < 6; k++)
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
    n_cmp++;
    if (q_count !== 3'd0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_drain got q%0d pend%0d want 0/0", q_count, exp_q.size());
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    logic acc;
    rs1_rf = 32'h11;
    rs2_rf = 32'h22;
    rs2_addr = 5'd4;
    step(1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 32'd0, acc);
    rs1_addr = 5'd3;
    #1;
    n_cmp++;
    if (rs1_val !== 32'hAA || rs2_val !== 32'h22) begin
      n_bad++;
      $display("FAIL byp_hit got %h/%h want aa/22", rs1_val, rs2_val);
    end
    rs1_addr = 5'd0;
    #1;
    n_cmp++;
    if (rs1_val !== 32'h11) begin
      n_bad++;
      $display("FAIL byp_x0 got %h want 11", rs1_val);
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
`ifdef WB_BYPASS_EN
    rs1_addr = '0; rs2_addr = '0; rs1_rf = '0; rs2_rf = '0;
`endif
    model_clear();
    test_reset();
    test_alu();
    test_queue_full();
    test_priority();
    test_x0();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
